// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and helpers for the I2C configuration master
// and its register table.
package i2c_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK_A,
        S_REG,
        S_ACK_R,
        S_DATA,
        S_ACK_D,
        S_STOP,
        S_GAP,
        S_FINISH
    } state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [7:0] DEV_ADDR_DEFAULT = 8'h42;

    function automatic logic [7:0] entry_reg(input logic [15:0] e);
        return e[15:8];
    endfunction

    function automatic logic [7:0] entry_val(input logic [15:0] e);
        return e[7:0];
    endfunction

    // Returns {scl, sda_pull_low} for a bus position.
    function automatic logic [1:0] bus_drive(
        input state_e     s,
        input logic [1:0] q,
        input logic       bit_v
    );
        logic scl_hi;
        logic [1:0] r;
        scl_hi = (q == Q1) || (q == Q2);
        case (s)
            S_START: r = (q == Q0) ? 2'b11 : 2'b01;
            S_ADDR, S_REG, S_DATA: r = {scl_hi, ~bit_v};
            S_ACK_A, S_ACK_R, S_ACK_D: r = {scl_hi, 1'b0};
            S_STOP: begin
                case (q)
                    Q0: r = 2'b01;
                    Q1: r = 2'b11;
                    default: r = 2'b10;
                endcase
            end
            default: r = 2'b10;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/i2c_config_rom.sv
// i2c_config_rom: registered 256x16 sensor register table,
// one {reg, value} word per entry; unused entries read as zero.
module i2c_config_rom (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [7:0]  iAddr,
    output logic [15:0] oData
);

    logic [15:0] data_d;
    logic [15:0] data_q;

    always_comb begin
        case (iAddr)
            8'd0:    data_d = 16'h1280;
            8'd1:    data_d = 16'h1104;
            8'd2:    data_d = 16'h3A04;
            8'd3:    data_d = 16'h40D0;
            8'd4:    data_d = 16'h1714;
            8'd5:    data_d = 16'h1802;
            default: data_d = 16'h0000;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) data_q <= '0;
        else         data_q <= data_d;
    end

    assign oData = data_q;

endmodule

// File: rtl/i2c_config_master.sv
// i2c_config_master: I2C write engine that walks a {reg, value} table
// and writes each pair to one device, retrying NACKed transfers.
module i2c_config_master
    import i2c_pkg::*;
#(
    parameter int         CLK_DIV   = 25,
    parameter logic [7:0] DEV_ADDR  = DEV_ADDR_DEFAULT,
    parameter int         NUM_REGS  = 16,
    parameter int         MAX_RETRY = 3
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iStart,
    output logic        oSCL,
    inout  wire         ioSDA,
    output logic [7:0]  oIndex,
    input  logic [15:0] iEntry,
    output logic        oBusy,
    output logic        oDone,
    output logic        oError,
    output logic [3:0]  oRetries
);

    localparam logic [15:0] QTC  = 16'(CLK_DIV - 1);
    localparam logic [7:0]  LAST = 8'(NUM_REGS - 1);
    localparam logic [7:0]  RMAX = 8'(MAX_RETRY);

    state_e      state_q, state_d;
    logic [15:0] qcnt_q, qcnt_d;
    logic [1:0]  qph_q, qph_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  rty_q, rty_d;
    logic [3:0]  rtot_q, rtot_d;
    logic [15:0] entry_q, entry_d;
    logic        nack_q, nack_d;
    logic        retry_q, retry_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        scl_q, scl_d;
    logic        sdal_q, sdal_d;
    logic        tc;
    logic        in_ack;
    logic [7:0]  cur_byte;

    always_comb begin
        tc      = (qcnt_q == QTC);
        in_ack  = (state_q == S_ACK_A) || (state_q == S_ACK_R)
               || (state_q == S_ACK_D);
        state_d = state_q;
        qph_d   = qph_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        rty_d   = rty_q;
        rtot_d  = rtot_q;
        entry_d = entry_q;
        nack_d  = nack_q;
        retry_d = retry_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        qcnt_d  = (state_q == S_IDLE || state_q == S_FINISH || tc)
                ? 16'd0 : qcnt_q + 16'd1;
        // ROM answers one cycle after oIndex moves, so latch on cycle 1
        if (state_q == S_START && qph_q == Q0 && qcnt_q == 16'd1)
            entry_d = iEntry;
        if (in_ack && qph_q == Q1 && tc)
            nack_d = ioSDA;
        case (state_q)
            S_IDLE: if (iStart) begin
                state_d = S_START;
                qph_d   = Q0;
                idx_d   = 8'd0;
                rty_d   = 8'd0;
                rtot_d  = 4'd0;
                busy_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b0;
            end
            S_START: if (tc) begin
                if (qph_q == Q0) qph_d = Q1;
                else begin
                    state_d = S_ADDR;
                    qph_d   = Q0;
                    bit_d   = 3'd7;
                end
            end
            S_ADDR, S_REG, S_DATA: if (tc) begin
                if (qph_q != Q3) qph_d = qph_q + 2'd1;
                else begin
                    qph_d = Q0;
                    if (bit_q != 3'd0) bit_d = bit_q - 3'd1;
                    else state_d = (state_q == S_ADDR) ? S_ACK_A
                                 : (state_q == S_REG)  ? S_ACK_R
                                 : S_ACK_D;
                end
            end
            S_ACK_A, S_ACK_R, S_ACK_D: if (tc) begin
                if (qph_q != Q3) qph_d = qph_q + 2'd1;
                else begin
                    qph_d   = Q0;
                    bit_d   = 3'd7;
                    retry_d = nack_q;
                    if (nack_q || state_q == S_ACK_D) state_d = S_STOP;
                    else state_d = (state_q == S_ACK_A) ? S_REG : S_DATA;
                end
            end
            S_STOP: if (tc) begin
                if (qph_q != Q2) qph_d = qph_q + 2'd1;
                else begin
                    state_d = S_GAP;
                    qph_d   = Q0;
                end
            end
            S_GAP: if (tc) begin
                if (qph_q != Q3) qph_d = qph_q + 2'd1;
                else begin
                    qph_d = Q0;
                    if (retry_q && rty_q < RMAX) begin
                        state_d = S_START;
                        rty_d   = rty_q + 8'd1;
                        rtot_d  = (rtot_q == 4'hF) ? rtot_q
                                : rtot_q + 4'd1;
                    end else if (retry_q || idx_q == LAST) begin
                        state_d = S_FINISH;
                        err_d   = retry_q;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_START;
                        idx_d   = idx_q + 8'd1;
                        rty_d   = 8'd0;
                    end
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        case (state_d)
            S_REG:   cur_byte = entry_reg(entry_q);
            S_DATA:  cur_byte = entry_val(entry_q);
            default: cur_byte = DEV_ADDR;
        endcase
        {scl_d, sdal_d} = bus_drive(state_d, qph_d, cur_byte[bit_d]);
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            qph_q   <= Q0;
            bit_q   <= 3'd7;
            idx_q   <= '0;
            rty_q   <= '0;
            rtot_q  <= '0;
            entry_q <= '0;
            nack_q  <= 1'b0;
            retry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            scl_q   <= 1'b1;
            sdal_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            qph_q   <= qph_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            rty_q   <= rty_d;
            rtot_q  <= rtot_d;
            entry_q <= entry_d;
            nack_q  <= nack_d;
            retry_q <= retry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            scl_q   <= scl_d;
            sdal_q  <= sdal_d;
        end
    end

    assign ioSDA    = sdal_q ? 1'b0 : 1'bz;
    assign oSCL     = scl_q;
    assign oIndex   = idx_q;
    assign oBusy    = busy_q;
    assign oDone    = done_q;
    assign oError   = err_q;
    assign oRetries = rtot_q;

endmodule
